gc_tx_arbiter: RTL and testbench
================================

Name: gc_tx_arbiter

Overview:
- Multi-lane transmit stage for the garbler. Replaces the single-lane, no-backpressure send path.
- Collects tagged records (keys, input labels, garbled tables) from NCH garbling lanes through per-lane FIFOs.
- Packs serial output-mask bits into 2K-bit words.
- Streams everything over one ready/valid bus using the existing tag encoding.

Parameters:
S, 20, index width
K, 128, label/data half-word width
NCH, 2, number of garbling lanes (1..8)
DEPTH, 8, per-lane FIFO depth in records, power of 2, >=2

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  pulse: clear mask packer/counters, enter RUN
finish  in  1  pulse: no more records after current FIFO contents, enter FLUSH
in_valid  in  NCH  per-lane record valid
in_ready  out  NCH  per-lane ready, = ~full[c]
in_tag  in  3*NCH  per-lane tag (lane c at [3c+2:3c])
in_index0, in_index1  in  S*NCH  per-lane indices
in_data0, in_data1  in  K*NCH  per-lane data
mask_valid  in  1  output-mask bit valid
mask_bit  in  1  output-mask bit
mask_ready  out  1  packer can accept a bit
out_valid  out  1  output record valid
out_ready  in  1  downstream accepts
tag  out  3  000 none, 001 keys, 010 garbled table, 011 masks, 1xx input labels
index0, index1  out  S  record indices
data0, data1  out  K  record data
done  out  1  all records and mask words delivered

Behaviour:
- Interface: single clock clk; rst synchronous, active-high.
- Reset values:
  - out_valid=0, tag=000, index0=index1=all ones, data0=data1=0.
  - done=0, FSM=IDLE, all FIFOs empty, so in_ready=all 1.
  - mask_ready=1, mask count=0, word count=0, round-robin pointer=0.
- Lane push: on in_valid[c]&in_ready[c]. Records with tag 000 are accepted but not enqueued.
- Requesters: NCH lane FIFOs (request = non-empty) plus the mask packer as requester NCH (request = full word pending, or partial word in FLUSH).
- Round-robin arbitration:
  - Scan starts at the requester after the last granted one.
  - Grant only when the output register is empty or being consumed (~out_valid|out_ready).
  - Granted head is popped into the output register the same edge.
- Output register: data, tag and index held stable while out_valid&~out_ready. Latency from push into an empty lane to out_valid is 2 cycles when no other requester is active.
- Mask packer:
  - Bit n of the current word goes to data0[n] for n<K, else data1[n-K].
  - Word completes after 2K bits. mask_ready=0 while a completed word is pending.
  - Emitted with tag 011, index0=index1=word number (wraps at 2**S).
  - Accept and emit in the same cycle is allowed; the new bit starts the next word.
- FSM states and transitions:
  - IDLE: outputs inactive. start -> RUN.
  - RUN: normal operation. finish -> FLUSH.
  - FLUSH: lanes still drain. Pending mask bits (count>0) are emitted as one zero-padded word. When all FIFOs are empty, no word is pending and the output register is empty (or its last record is accepted) -> DONE.
  - DONE: done=1 held. start -> RUN, clearing done, mask count and word count.
- Simultaneous events:
  - Push to a full FIFO is impossible (in_ready=0).
  - Push and pop on the same lane in the same cycle are both performed.
  - start and finish together: start wins.
  - finish in IDLE is ignored.
  - mask_valid in IDLE/DONE is ignored.
- rst mid-transfer drops all FIFO contents and any pending output without completing the handshake.

Optional Feature:
- Macro: GC_TX_STATS_EN.
- With it defined, three extra outputs:
  - gt_count (S bits): count of tag-010 records accepted downstream.
  - label_count (S bits): count of tag-1xx records.
  - stall_cycles (32 bits): cycles with out_valid&~out_ready.
- All three are cleared on rst and on start, and saturate at all ones.
- Without the macro these ports do not exist and no counter logic is built.

Test Plan:
- NCH=2, DEPTH=4, out_ready=1; lane0 pushes tag 010, index0=4, index1=5, data0=0xA; lanes otherwise idle -> out_valid exactly 2 cycles later with identical fields, then tag 000 / out_valid=0.
- Both lanes push 4 records each continuously, out_ready=1 -> output alternates lane0, lane1, ... (8 records, no loss, no duplicate); in_ready stays 1.
- out_ready=0 for 10 cycles while lane0 pushes 5 records -> in_ready[0]=0 after 4 queued (plus 1 in output register); output fields stable throughout; all 5 emitted in order after release.
- 2K+3=259 mask bits, then finish -> tag 011 word 0 with all 256 bits, then word 1 with bits 0..2 in data0[2:0] and the rest 0; done=1 after the last accept.
- Push 000-tagged record -> accepted, never emitted. start in DONE -> done=0 and next mask word index=0.
- Assert rst while out_valid=1 and FIFOs hold 3 records -> next cycle out_valid=0, in_ready all 1, and nothing from before reset is ever emitted.

Source files
------------

// File: rtl/gc_tx_arbiter.sv
// rtl/gc_tx_arbiter.sv - multi-lane garbler transmit arbiter with output-mask packer
//
// Collects tagged records from NCH garbling lanes through per-lane FIFOs,
// packs serial output-mask bits into 2K-bit words, and streams everything
// over one ready/valid bus.
//
// Optional feature macro: GC_TX_STATS_EN (adds gt_count, label_count,
// stall_cycles outputs and their counters).
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 pulse: clear mask packer/counters, enter RUN
//   finish                pulse: no more records, enter FLUSH
//   in_valid/in_ready     per-lane record handshake (NCH bits)
//   in_tag                per-lane tag, lane c at [3c+2:3c]
//   in_index0/in_index1   per-lane indices (S bits per lane)
//   in_data0/in_data1     per-lane data (K bits per lane)
//   mask_valid/mask_bit   serial output-mask bit input
//   mask_ready            packer can accept a bit
//   out_valid/out_ready   output record handshake
//   tag                   000 none, 001 keys, 010 garbled table, 011 masks, 1xx labels
//   index0/index1         output record indices
//   data0/data1           output record data
//   done                  all records and mask words delivered
//   gt_count, label_count, stall_cycles   (GC_TX_STATS_EN only)

module gc_tx_arbiter #(
  parameter int S     = 20,
  parameter int K     = 128,
  parameter int NCH   = 2,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             finish,
  input  logic [NCH-1:0]   in_valid,
  output logic [NCH-1:0]   in_ready,
  input  logic [3*NCH-1:0] in_tag,
  input  logic [S*NCH-1:0] in_index0,
  input  logic [S*NCH-1:0] in_index1,
  input  logic [K*NCH-1:0] in_data0,
  input  logic [K*NCH-1:0] in_data1,
  input  logic             mask_valid,
  input  logic             mask_bit,
  output logic             mask_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       tag,
  output logic [S-1:0]     index0,
  output logic [S-1:0]     index1,
  output logic [K-1:0]     data0,
  output logic [K-1:0]     data1,
  output logic             done
`ifdef GC_TX_STATS_EN
  ,
  output logic [S-1:0]     gt_count,
  output logic [S-1:0]     label_count,
  output logic [31:0]      stall_cycles
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NR = NCH + 1;           // lanes plus the mask packer
  localparam int PW = $clog2(NR);
  localparam int RW = 3 + 2*S + 2*K;     // packed record width
  localparam int MW = 2*K;               // mask word width in bits
  localparam int CW = $clog2(MW) + 1;    // mask bit counter, holds 0..MW

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_t;

  state_t state;

  // Lane FIFOs
  logic [RW-1:0] mem    [NCH][DEPTH];
  logic [AW-1:0] wr_ptr [NCH];
  logic [AW-1:0] rd_ptr [NCH];
  logic [AW:0]   count  [NCH];
  logic [RW-1:0] rec_in [NCH];
  logic [RW-1:0] head   [NCH];
  logic [NCH-1:0] push;
  logic [NCH-1:0] pop;
  logic [NCH-1:0] lane_req;

  // Mask packer
  logic [MW-1:0] mask_buf;
  logic [CW-1:0] mask_cnt;
  logic          mask_pending;
  logic [S-1:0]  word_num;
  logic          mask_req;
  logic          mask_acc;

  // Arbiter
  logic [PW-1:0] rr_ptr;
  logic [NR-1:0] req;
  logic          active;
  logic          can_load;
  logic          gnt_valid;
  logic [PW-1:0] gnt_idx;
  logic          mask_gnt;
  logic [RW-1:0] sel_head;

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      rec_in[c]   = {in_tag[3*c +: 3], in_index0[S*c +: S], in_index1[S*c +: S],
                     in_data0[K*c +: K], in_data1[K*c +: K]};
      in_ready[c] = (count[c] != (AW+1)'(DEPTH));
      // tag-000 records complete the handshake but are dropped here
      push[c]     = in_valid[c] & in_ready[c] & (in_tag[3*c +: 3] != 3'b000);
      lane_req[c] = (count[c] != '0);
      head[c]     = mem[c][rd_ptr[c]];
    end
  end

  assign active     = (state == ST_RUN) || (state == ST_FLUSH);
  assign mask_ready = ~mask_pending;
  assign mask_acc   = mask_valid & ~mask_pending & active & ~start;
  // In FLUSH a partial word is also a request so it leaves zero-padded.
  assign mask_req   = mask_pending | ((state == ST_FLUSH) && (mask_cnt != '0));
  assign req        = {mask_req, lane_req};
  assign can_load   = active & (~out_valid | out_ready);

  // Round-robin: scan starts at rr_ptr, which points one past the last grant.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NR; i++) begin
      if (!gnt_valid && req[(int'(rr_ptr) + i) % NR]) begin
        gnt_valid = 1'b1;
        gnt_idx   = PW'((int'(rr_ptr) + i) % NR);
      end
    end
    if (!can_load) begin
      gnt_valid = 1'b0;
    end
  end

  assign mask_gnt = gnt_valid && (gnt_idx == PW'(NCH));

  always_comb begin
    sel_head = head[0];
    for (int c = 0; c < NCH; c++) begin
      pop[c] = gnt_valid && (gnt_idx == PW'(c));
      if (gnt_idx == PW'(c)) begin
        sel_head = head[c];
      end
    end
  end

  // FIFO storage carries no reset; only the pointers define contents.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (push[c]) begin
        mem[c][wr_ptr[c]] <= rec_in[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (push[c]) begin
          wr_ptr[c] <= wr_ptr[c] + AW'(1);
        end
        if (pop[c]) begin
          rd_ptr[c] <= rd_ptr[c] + AW'(1);
        end
        if (push[c] && !pop[c]) begin
          count[c] <= count[c] + (AW+1)'(1);
        end else if (!push[c] && pop[c]) begin
          count[c] <= count[c] - (AW+1)'(1);
        end
      end
    end
  end

  // FSM, output register, mask packer and arbitration pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      done         <= 1'b0;
      out_valid    <= 1'b0;
      tag          <= 3'b000;
      index0       <= '1;
      index1       <= '1;
      data0        <= '0;
      data1        <= '0;
      mask_buf     <= '0;
      mask_cnt     <= '0;
      mask_pending <= 1'b0;
      word_num     <= '0;
      rr_ptr       <= '0;
    end else begin
      // Output register: load on grant, otherwise drain when accepted.
      if (gnt_valid) begin
        out_valid <= 1'b1;
        rr_ptr    <= (gnt_idx == PW'(NCH)) ? '0 : gnt_idx + PW'(1);
        if (mask_gnt) begin
          tag    <= 3'b011;
          index0 <= word_num;
          index1 <= word_num;
          data0  <= mask_buf[K-1:0];
          data1  <= mask_buf[MW-1:K];
        end else begin
          {tag, index0, index1, data0, data1} <= sel_head;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
        tag       <= 3'b000;
      end

      // Mask packer. A bit accepted while the current word is emitted
      // becomes bit 0 of the next word.
      if (start) begin
        mask_buf     <= '0;
        mask_cnt     <= '0;
        mask_pending <= 1'b0;
        word_num     <= '0;
      end else if (mask_gnt) begin
        mask_pending <= 1'b0;
        word_num     <= word_num + S'(1);
        if (mask_acc) begin
          mask_buf <= {{(MW-1){1'b0}}, mask_bit};
          mask_cnt <= CW'(1);
        end else begin
          mask_buf <= '0;
          mask_cnt <= '0;
        end
      end else if (mask_acc) begin
        mask_buf[mask_cnt[CW-2:0]] <= mask_bit;
        mask_cnt                   <= mask_cnt + CW'(1);
        if (mask_cnt == CW'(MW-1)) begin
          mask_pending <= 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            done  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (start) begin
            done <= 1'b0;
          end else if (finish) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (start) begin
            state <= ST_RUN;
            done  <= 1'b0;
          end else if (~|req && ~|push && !mask_acc && (!out_valid || out_ready)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (start) begin
            state <= ST_RUN;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef GC_TX_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || start) begin
      gt_count     <= '0;
      label_count  <= '0;
      stall_cycles <= '0;
    end else begin
      if (out_valid && out_ready) begin
        if ((tag == 3'b010) && (gt_count != '1)) begin
          gt_count <= gt_count + S'(1);
        end
        if (tag[2] && (label_count != '1)) begin
          label_count <= label_count + S'(1);
        end
      end
      if (out_valid && !out_ready && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gc_tx_arbiter.sv
// tb/tb_gc_tx_arbiter.sv - scoreboard testbench for gc_tx_arbiter
module tb_gc_tx_arbiter;

  localparam int S     = 20;
  localparam int K     = 128;
  localparam int NCH   = 2;
  localparam int DEPTH = 4;
  localparam int MW    = 2*K;

  typedef struct packed {
    logic [2:0]   tag;
    logic [S-1:0] i0;
    logic [S-1:0] i1;
    logic [K-1:0] d0;
    logic [K-1:0] d1;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start, finish;
  logic [NCH-1:0]   in_valid, in_ready;
  logic [3*NCH-1:0] in_tag;
  logic [S*NCH-1:0] in_index0, in_index1;
  logic [K*NCH-1:0] in_data0, in_data1;
  logic             mask_valid, mask_bit, mask_ready;
  logic             out_valid, out_ready;
  logic [2:0]       tag;
  logic [S-1:0]     index0, index1;
  logic [K-1:0]     data0, data1;
  logic             done;

  gc_tx_arbiter #(.S(S), .K(K), .NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
    .in_index0(in_index0), .in_index1(in_index1),
    .in_data0(in_data0), .in_data1(in_data1),
    .mask_valid(mask_valid), .mask_bit(mask_bit), .mask_ready(mask_ready),
    .out_valid(out_valid), .out_ready(out_ready), .tag(tag),
    .index0(index0), .index1(index1), .data0(data0), .data1(data1),
    .done(done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  rec_t q0[$], q1[$], mq[$];
  int   src_log[$];
  logic [MW-1:0] mbuf;
  int   mcnt;
  int   wn;
  bit   running;
  bit   prev_stall;
  rec_t prev_rec;

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected or not seen", name);
  endtask

  function automatic rec_t rand_rec(input int lane, input logic [2:0] t);
    rec_t r;
    logic [3:0] l;
    l      = lane[3:0];
    r.tag  = t;
    r.i0   = S'($urandom);
    r.i1   = S'($urandom);
    r.d0   = {$urandom, $urandom, $urandom, $urandom};
    r.d1   = {$urandom, $urandom, $urandom, $urandom};
    r.d1[K-1 -: 4] = l;   // lane stamp so the monitor can pick the queue
    return r;
  endfunction

  // Mask words: 2K bits, bit n -> data0[n] / data1[n-K], index = word number
  function automatic rec_t mask_word(input logic [MW-1:0] b, input int n);
    rec_t r;
    r.tag = 3'b011;
    r.i0  = S'(n);
    r.i1  = S'(n);
    r.d0  = b[K-1:0];
    r.d1  = b[MW-1:K];
    return r;
  endfunction

  task automatic model_bit(input logic b);
    mbuf[mcnt] = b;
    mcnt++;
    if (mcnt == MW) begin
      mq.push_back(mask_word(mbuf, wn));
      wn++;
      mbuf = '0;
      mcnt = 0;
    end
  endtask

  // Monitor: records accepted inputs into the model and scores outputs.
  always @(negedge clk) begin : mon
    rec_t got, exp, r;
    int   lane;
    bit   have;
    if (rst) begin
      prev_stall = 0;
    end else begin
      got = {tag, index0, index1, data0, data1};
      if (prev_stall) check("hold_stable", {out_valid, got}, {1'b1, prev_rec});
      for (int c = 0; c < NCH; c++) begin
        if (in_valid[c] && in_ready[c] && in_tag[3*c +: 3] != 3'b000) begin
          r = {in_tag[3*c +: 3], in_index0[S*c +: S], in_index1[S*c +: S],
               in_data0[K*c +: K], in_data1[K*c +: K]};
          if (c == 0) q0.push_back(r);
          else        q1.push_back(r);
        end
      end
      if (running && mask_valid && mask_ready) model_bit(mask_bit);
      if (out_valid && out_ready) begin
        have = 0;
        exp  = '0;
        lane = int'(data1[K-1 -: 4]);
        if (tag == 3'b011) begin
          lane = NCH;
          if (mq.size() > 0) begin exp = mq.pop_front(); have = 1; end
        end else if (tag != 3'b000 && lane == 0) begin
          if (q0.size() > 0) begin exp = q0.pop_front(); have = 1; end
        end else if (tag != 3'b000 && lane == 1) begin
          if (q1.size() > 0) begin exp = q1.pop_front(); have = 1; end
        end
        if (have) check("out_record", got, exp);
        else      note_fail("unexpected_output");
        src_log.push_back(lane);
      end
      prev_stall = out_valid && !out_ready;
      prev_rec   = got;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_lane(input int c, input rec_t r);
    in_tag[3*c +: 3]    = r.tag;
    in_index0[S*c +: S] = r.i0;
    in_index1[S*c +: S] = r.i1;
    in_data0[K*c +: K]  = r.d0;
    in_data1[K*c +: K]  = r.d1;
  endtask

  task automatic do_start();
    step();
    start = 1;
    mbuf = '0; mcnt = 0; wn = 0;
    step();
    start   = 0;
    running = 1;
  endtask

  task automatic do_finish();
    step();
    finish = 1;
    step();
    finish = 0;
    if (mcnt > 0) begin
      mq.push_back(mask_word(mbuf, wn));
      wn++;
      mbuf = '0;
      mcnt = 0;
    end
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!done && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!done) note_fail("done_timeout");
    else begin
      check("done_drained", 320'(q0.size() + q1.size() + mq.size()), 320'd0);
      check("done_out_idle", 320'(out_valid), 320'd0);
    end
    running = 0;
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((q0.size() + q1.size() + mq.size() != 0 || out_valid) && n < bound);
    if (q0.size() + q1.size() + mq.size() != 0 || out_valid) note_fail("drain_timeout");
  endtask

  task automatic push_n(input int lane, input int n, input logic [2:0] t);
    int   acc = 0;
    int   cyc = 0;
    rec_t r   = rand_rec(lane, t);
    while (acc < n && cyc < 60) begin
      step();
      in_valid[lane] = 1;
      drive_lane(lane, r);
      @(negedge clk);
      if (in_ready[lane]) begin
        acc++;
        r = rand_rec(lane, t);
      end
      cyc++;
    end
    step();
    in_valid[lane] = 0;
    if (acc < n) note_fail("push_timeout");
  endtask

  task automatic send_bits(input int n);
    int acc = 0;
    int cyc = 0;
    while (acc < n && cyc < 4*n + 50) begin
      step();
      mask_valid = 1;
      mask_bit   = 1'($urandom_range(1, 0));
      @(negedge clk);
      if (mask_ready) acc++;
      cyc++;
    end
    step();
    mask_valid = 0;
    if (acc < n) note_fail("mask_timeout");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    rec_t r;
    int   alt_bad;
    bit   saw;
    rst = 1; start = 0; finish = 0; in_valid = '0; in_tag = '0;
    in_index0 = '0; in_index1 = '0; in_data0 = '0; in_data1 = '0;
    mask_valid = 0; mask_bit = 0; out_ready = 0;
    mbuf = '0; mcnt = 0; wn = 0; running = 0; prev_stall = 0;
    repeat (2) step();
    rst = 0;
    @(negedge clk);
    check("rst_out_valid", 320'(out_valid), 320'd0);
    check("rst_tag", 320'(tag), 320'd0);
    check("rst_index", {index0, index1}, {{S{1'b1}}, {S{1'b1}}});
    check("rst_data", {data0, data1}, 320'd0);
    check("rst_done", 320'(done), 320'd0);
    check("rst_in_ready", 320'(in_ready), 320'(2'b11));
    check("rst_mask_ready", 320'(mask_ready), 320'd1);

    do_start();
    out_ready = 1;

    // Single record latency: valid exactly two cycles after presentation
    step();
    r = rand_rec(0, 3'b010);
    r.i0 = S'(4); r.i1 = S'(5); r.d0 = K'(8'h0A);
    in_valid[0] = 1;
    drive_lane(0, r);
    @(negedge clk);
    check("lat_c0", 320'(out_valid), 320'd0);
    step();
    in_valid[0] = 0;
    @(negedge clk);
    check("lat_c1", 320'(out_valid), 320'd0);
    step();
    @(negedge clk);
    check("lat_c2_valid", 320'(out_valid), 320'd1);
    check("lat_c2_tag", 320'(tag), 320'(3'b010));
    step();
    @(negedge clk);
    check("lat_c3_idle", {out_valid, tag}, 320'd0);

    // Both lanes busy: output must alternate
    src_log.delete();
    for (int i = 0; i < 4; i++) begin
      step();
      in_valid = 2'b11;
      drive_lane(0, rand_rec(0, 3'b001));
      drive_lane(1, rand_rec(1, 3'b100));
      @(negedge clk);
      check("rr_in_ready", 320'(in_ready), 320'(2'b11));
    end
    step();
    in_valid = '0;
    wait_drain(100);
    alt_bad = 0;
    for (int i = 1; i < src_log.size(); i++)
      if (src_log[i] == src_log[i-1]) alt_bad++;
    check("rr_count", 320'(src_log.size()), 320'd8);
    check("rr_alternate", 320'(alt_bad), 320'd0);

    // Backpressure: 5 records into depth-4 lane with the output stalled
    out_ready = 0;
    push_n(0, 5, 3'b010);
    @(negedge clk);
    check("bp_full", 320'(in_ready[0]), 320'd0);
    repeat (3) step();
    out_ready = 1;
    wait_drain(100);

    // Tag 000 record: accepted, never emitted
    step();
    in_valid[1] = 1;
    drive_lane(1, rand_rec(1, 3'b000));
    @(negedge clk);
    check("zero_tag_ready", 320'(in_ready[1]), 320'd1);
    step();
    in_valid[1] = 0;
    saw = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) saw = 1;
    end
    check("zero_tag_dropped", 320'(saw), 320'd0);

    // Randomised traffic with backpressure and mask bits
    repeat (400) begin
      step();
      out_ready  = ($urandom_range(3, 0) != 0);
      mask_valid = ($urandom_range(2, 0) == 0);
      mask_bit   = 1'($urandom_range(1, 0));
      for (int c = 0; c < NCH; c++) begin
        logic [2:0] t;
        t = 3'($urandom_range(7, 0));
        if (t == 3'b011) t = 3'b000;
        in_valid[c] = 1'($urandom_range(1, 0));
        drive_lane(c, rand_rec(c, t));
      end
    end
    step();
    in_valid = '0; mask_valid = 0; out_ready = 1;
    do_finish();
    wait_done(2000);

    // Restart from DONE: done clears, word numbering restarts at 0
    do_start();
    @(negedge clk);
    check("restart_done", 320'(done), 320'd0);
    send_bits(2*K + 3);
    do_finish();
    wait_done(200);

    // Reset in the middle of a stalled transfer
    do_start();
    out_ready = 0;
    push_n(0, 4, 3'b001);
    step();
    rst = 1;
    running = 0;
    q0.delete(); q1.delete(); mq.delete();
    step();
    rst = 0;
    @(negedge clk);
    check("rst_mid_valid", 320'(out_valid), 320'd0);
    check("rst_mid_ready", 320'(in_ready), 320'(2'b11));
    do_start();
    out_ready = 1;
    push_n(0, 2, 3'b101);
    repeat (5) step();
    do_finish();
    wait_done(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
